// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domains in reset, then releases them one by one
// in index order, gated by a per-domain ready handshake with a bounded timeout.
module reset_sequencer #(
   parameter int NUM_STAGES     = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  SW_RST_REQ,
   input  logic                  WDOG_RST_REQ,
   input  logic [NUM_STAGES-1:0] STAGE_RDY,
   output logic [NUM_STAGES-1:0] OUT_RST_N,
   output logic                  BUSY,
   output logic [NUM_STAGES-1:0] TIMEOUT_ERR,
   output logic [1:0]            LAST_CAUSE
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_STAGE = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   state_t                  state_r, state_s;
   logic [IDX_W-1:0]        idx_r, idx_s, idx_inc_s;
   logic [CNT_W-1:0]        cnt_r, cnt_s;
   logic [NUM_STAGES-1:0]   out_rst_n_r, out_rst_n_s;
   logic                    busy_r, busy_s;
   logic [NUM_STAGES-1:0]   timeout_err_r, timeout_err_s;
   logic [1:0]              last_cause_r, last_cause_s;
   logic                    req_s;
   logic                    rdy_sel_s;
   logic                    advance_s;

   // Next-state and next-output computation for the sequencing FSM.
   always_comb begin
      state_s       = state_r;
      idx_s         = idx_r;
      cnt_s         = cnt_r;
      out_rst_n_s   = out_rst_n_r;
      busy_s        = busy_r;
      timeout_err_s = timeout_err_r;
      last_cause_s  = last_cause_r;
      idx_inc_s     = idx_r + IDX_W'(1);
      req_s         = SW_RST_REQ | WDOG_RST_REQ;
      rdy_sel_s     = STAGE_RDY[idx_r];
      advance_s     = 1'b0;

      if (req_s) begin
         state_s       = ST_HOLD;
         idx_s         = '0;
         cnt_s         = '0;
         out_rst_n_s   = '0;
         busy_s        = 1'b1;
         timeout_err_s = '0;
         last_cause_s  = WDOG_RST_REQ ? 2'd2 : 2'd1;
      end else begin
         case (state_r)
            ST_HOLD: begin
               if (cnt_r == HOLD_LAST) begin
                  state_s        = ST_STAGE;
                  idx_s          = '0;
                  cnt_s          = '0;
                  out_rst_n_s[0] = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end
            ST_STAGE: begin
               // A ready stage waits out the stagger; a silent one is forced on at timeout.
               if ((cnt_r >= STAGGER_LAST) && rdy_sel_s) begin
                  advance_s = 1'b1;
               end else if ((cnt_r == TIMEOUT_LAST) && !rdy_sel_s) begin
                  advance_s            = 1'b1;
                  timeout_err_s[idx_r] = 1'b1;
               end else begin
                  advance_s = 1'b0;
               end

               if (advance_s) begin
                  cnt_s = '0;
                  if (idx_r == LAST_IDX) begin
                     state_s = ST_IDLE;
                     busy_s  = 1'b0;
                  end else begin
                     idx_s                  = idx_inc_s;
                     out_rst_n_s[idx_inc_s] = 1'b1;
                  end
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s     = ST_HOLD;
               idx_s       = '0;
               cnt_s       = '0;
               out_rst_n_s = '0;
               busy_s      = 1'b1;
            end
         endcase
      end
   end

   // State and output registers with synchronous power-on reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r       <= ST_HOLD;
         idx_r         <= '0;
         cnt_r         <= '0;
         out_rst_n_r   <= '0;
         busy_r        <= 1'b1;
         timeout_err_r <= '0;
         last_cause_r  <= 2'd0;
      end else begin
         state_r       <= state_s;
         idx_r         <= idx_s;
         cnt_r         <= cnt_s;
         out_rst_n_r   <= out_rst_n_s;
         busy_r        <= busy_s;
         timeout_err_r <= timeout_err_s;
         last_cause_r  <= last_cause_s;
      end
   end

   assign OUT_RST_N   = out_rst_n_r;
   assign BUSY        = busy_r;
   assign TIMEOUT_ERR = timeout_err_r;
   assign LAST_CAUSE  = last_cause_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requests and ready.
module tb_reset_sequencer;

   localparam int N = 3;
   localparam int H = 4;
   localparam int S = 2;
   localparam int T = 8;

   logic         CLK;
   logic         RST;
   logic         SW_RST_REQ;
   logic         WDOG_RST_REQ;
   logic [N-1:0] STAGE_RDY;
   logic [N-1:0] OUT_RST_N;
   logic         BUSY;
   logic [N-1:0] TIMEOUT_ERR;
   logic [1:0]   LAST_CAUSE;

   reset_sequencer #(
      .NUM_STAGES(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S),
      .TIMEOUT_CYCLES(T), .CNT_W(8)
   ) dut (
      .CLK(CLK), .RST(RST), .SW_RST_REQ(SW_RST_REQ), .WDOG_RST_REQ(WDOG_RST_REQ),
      .STAGE_RDY(STAGE_RDY), .OUT_RST_N(OUT_RST_N), .BUSY(BUSY),
      .TIMEOUT_ERR(TIMEOUT_ERR), .LAST_CAUSE(LAST_CAUSE)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: time of the last restart, count of released stages,
   // time of the latest release and first edge the active stage showed ready.
   int       now       = 0;
   int       e0        = 0;
   int       n_rel     = 0;
   int       last_rel  = 0;
   int       first_rdy = -1;
   bit       m_valid   = 1'b0;
   logic [N-1:0] m_err   = '0;
   logic [1:0]   m_cause = 2'd0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic advance_stage();
      n_rel++;
      last_rel  = now;
      first_rdy = -1;
   endtask

   task automatic model_step();
      now++;
      if (RST || SW_RST_REQ || WDOG_RST_REQ) begin
         m_valid = 1'b1;
         e0      = now;
         n_rel   = 0;
         m_err   = '0;
         m_cause = RST ? 2'd0 : (WDOG_RST_REQ ? 2'd2 : 2'd1);
      end else if (m_valid) begin
         if (n_rel == 0) begin
            if (now - e0 == H) begin
               n_rel     = 1;
               last_rel  = now;
               first_rdy = -1;
            end
         end else if (n_rel <= N) begin
            if (first_rdy < 0 && STAGE_RDY[n_rel-1]) first_rdy = now;
            if (first_rdy >= 0 && now - last_rel >= S) begin
               advance_stage();
            end else if (now - last_rel == T) begin
               m_err[n_rel-1] = 1'b1;
               advance_stage();
            end
         end
      end
   endtask

   function automatic int exp_out();
      int k;
      k = (n_rel > N) ? N : n_rel;
      return (1 << k) - 1;
   endfunction

   initial forever begin
      @(posedge CLK);
      model_step();
   end

   initial forever begin
      @(negedge CLK);
      if (m_valid) begin
         chk("model_out",   int'(OUT_RST_N),   exp_out());
         chk("model_busy",  int'(BUSY),        (n_rel <= N) ? 1 : 0);
         chk("model_err",   int'(TIMEOUT_ERR), int'(m_err));
         chk("model_cause", int'(LAST_CAUSE),  int'(m_cause));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   int     req_left;
   logic [N-1:0] dead;
   logic [2:0]   kind;

   initial begin
      RST = 1'b1; SW_RST_REQ = 1'b0; WDOG_RST_REQ = 1'b0; STAGE_RDY = 3'b111;

      // Power-on: three RST edges, all ready.
      step(3);
      chk("rst_out", int'(OUT_RST_N), 0);
      chk("rst_busy", int'(BUSY), 1);
      chk("rst_err", int'(TIMEOUT_ERR), 0);
      chk("rst_cause", int'(LAST_CAUSE), 0);
      RST = 1'b0;
      step(3); chk("po_e3", int'(OUT_RST_N), 3'b000);
      step(1); chk("po_e4", int'(OUT_RST_N), 3'b001);
      step(2); chk("po_e6", int'(OUT_RST_N), 3'b011);
      step(2); chk("po_e8", int'(OUT_RST_N), 3'b111);
      step(1); chk("po_busy_e9", int'(BUSY), 1);
      step(1); chk("po_busy_e10", int'(BUSY), 0);
      chk("po_err", int'(TIMEOUT_ERR), 0);

      // Stage 1 never ready: timeout path.
      SW_RST_REQ = 1'b1; STAGE_RDY = 3'b101;
      step(1); SW_RST_REQ = 1'b0;
      chk("to_cause", int'(LAST_CAUSE), 1);
      chk("to_out0", int'(OUT_RST_N), 3'b000);
      step(6);  chk("to_e6", int'(OUT_RST_N), 3'b011);
      step(7);  chk("to_e13", int'(OUT_RST_N), 3'b011);
      chk("to_err_e13", int'(TIMEOUT_ERR), 3'b000);
      step(1);  chk("to_e14", int'(OUT_RST_N), 3'b111);
      chk("to_err_e14", int'(TIMEOUT_ERR), 3'b010);
      step(1);  chk("to_busy_e15", int'(BUSY), 1);
      step(1);  chk("to_busy_e16", int'(BUSY), 0);

      // Stage 0 ready seen 5 edges after its release.
      SW_RST_REQ = 1'b1; STAGE_RDY = 3'b110;
      step(1); SW_RST_REQ = 1'b0;
      step(8); chk("late_e8", int'(OUT_RST_N), 3'b001);
      STAGE_RDY = 3'b111;
      step(1); chk("late_e9", int'(OUT_RST_N), 3'b011);
      step(1); chk("late_e10", int'(OUT_RST_N), 3'b011);
      step(1); chk("late_e11", int'(OUT_RST_N), 3'b111);

      // Software restart in the middle of stage 1.
      SW_RST_REQ = 1'b1; STAGE_RDY = 3'b000;
      step(1); SW_RST_REQ = 1'b0;
      step(12);
      chk("mid_out_e12", int'(OUT_RST_N), 3'b011);
      chk("mid_err_e12", int'(TIMEOUT_ERR), 3'b001);
      SW_RST_REQ = 1'b1;
      step(1); SW_RST_REQ = 1'b0; STAGE_RDY = 3'b111;
      chk("mid_out", int'(OUT_RST_N), 3'b000);
      chk("mid_err", int'(TIMEOUT_ERR), 3'b000);
      chk("mid_cause", int'(LAST_CAUSE), 1);
      chk("mid_busy", int'(BUSY), 1);
      step(4); chk("mid_rerun_e4", int'(OUT_RST_N), 3'b001);
      step(6); chk("mid_rerun_busy", int'(BUSY), 0);

      // Cause priority.
      SW_RST_REQ = 1'b1; WDOG_RST_REQ = 1'b1;
      step(1); SW_RST_REQ = 1'b0; WDOG_RST_REQ = 1'b0;
      chk("prio_sw_wdog", int'(LAST_CAUSE), 2);
      step(12);
      RST = 1'b1; WDOG_RST_REQ = 1'b1;
      step(1); RST = 1'b0; WDOG_RST_REQ = 1'b0;
      chk("prio_rst_wdog", int'(LAST_CAUSE), 0);

      // Watchdog held for 10 edges.
      WDOG_RST_REQ = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("wdog_hold_out", int'(OUT_RST_N), 3'b000);
      end
      WDOG_RST_REQ = 1'b0;
      chk("wdog_cause", int'(LAST_CAUSE), 2);
      step(3); chk("wdog_e3", int'(OUT_RST_N), 3'b000);
      step(1); chk("wdog_e4", int'(OUT_RST_N), 3'b001);

      // Randomized requests and monotonic ready bits per sequence.
      req_left = 0;
      dead     = '0;
      for (int c = 0; c < 4000; c++) begin
         if (req_left > 0) begin
            req_left--;
            if (req_left == 0) begin
               RST = 1'b0; SW_RST_REQ = 1'b0; WDOG_RST_REQ = 1'b0;
            end
         end else if ($urandom_range(0, 49) == 0) begin
            kind = 3'($urandom_range(1, 7));
            RST = kind[0]; SW_RST_REQ = kind[1]; WDOG_RST_REQ = kind[2];
            req_left  = $urandom_range(1, 3);
            STAGE_RDY = '0;
            for (int i = 0; i < N; i++) dead[i] = ($urandom_range(0, 5) == 0);
         end else begin
            for (int i = 0; i < N; i++)
               if (!dead[i] && !STAGE_RDY[i] && $urandom_range(0, 5) == 0) STAGE_RDY[i] = 1'b1;
         end
         step(1);
      end
      RST = 1'b0; SW_RST_REQ = 1'b0; WDOG_RST_REQ = 1'b0;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
